keystroke_conditioner: RTL and testbench
========================================

KEYSTROKE_CONDITIONER -- requirements
Module: keystroke_conditioner

Interface
REQ-001 SHALL have parameter WIDTH, default 12, number of key channels.
REQ-002 SHALL have parameter DB_CYCLES, default 4, consecutive stable cycles needed to accept a level change.
REQ-003 SHALL have parameter REPEAT_DELAY, default 32, hold cycles before the first auto-repeat.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 8, cycles between subsequent auto-repeats.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, event queue depth, power of two; IDX_W = clog2(WIDTH).
REQ-006 SHALL have port clk_raw  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port keystroke  input  WIDTH  raw asynchronous key levels, 1 = pressed.
REQ-009 SHALL have port repeat_en  input  WIDTH  per-channel auto-repeat enable.
REQ-010 SHALL have port key_level  output  WIDTH  debounced key levels.
REQ-011 SHALL have port key_press  output  WIDTH  one-cycle pulse per debounced rising edge.
REQ-012 SHALL have port evt_valid  output  1  event queue non-empty.
REQ-013 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-014 SHALL have port evt_idx  output  IDX_W  channel index of head event.
REQ-015 SHALL have port evt_repeat  output  1  head event is an auto-repeat (0 = fresh press).
REQ-016 SHALL have port evt_overflow  output  1  sticky flag, an event was lost.

Function
REQ-017 SHALL pass each keystroke bit through a 2-flop synchroniser.
REQ-018 SHALL update key_level[i] only after the synchronised bit differs from key_level[i] for DB_CYCLES consecutive cycles; any matching cycle clears that channel's counter.
REQ-019 SHALL make key_level[i] change exactly 2+DB_CYCLES cycles after a clean keystroke[i] edge.
REQ-020 SHALL assert key_press[i], registered, in the same cycle key_level[i] first reads 1, for exactly one cycle.
REQ-021 SHALL generate no event on key release.
REQ-022 SHALL, when repeat_en[i]=1 and key_level[i] held, raise a repeat request REPEAT_DELAY cycles after key_press[i], then every REPEAT_PERIOD cycles; the per-channel hold counter clears on release or repeat_en[i]=0.
REQ-023 SHALL keep a per-channel pending bit plus repeat flag; a press or repeat request sets it; a press overrides a pending repeat flag to 0.
REQ-024 SHALL each cycle push the lowest-index pending channel into the FIFO as {idx, repeat} if count < FIFO_DEPTH at cycle start, clearing that pending bit.
REQ-025 SHALL never push when full, even if a pop occurs the same cycle; push+pop when not full leaves count unchanged.
REQ-026 SHALL set evt_overflow when a request arrives on a channel whose pending bit is set and is not being pushed that cycle; the request is coalesced; the flag clears only on rst.
REQ-027 SHALL drive evt_valid = (count != 0); evt_idx/evt_repeat show the head entry; pop on evt_valid && evt_ready; head stable while evt_valid && !evt_ready.
REQ-028 SHALL preserve event order (FIFO), with same-cycle presses ordered by ascending index.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear synchronisers, debounce and hold counters, key_level, key_press, pending bits, FIFO pointers/count, evt_valid and evt_overflow to 0; evt_idx/evt_repeat read 0.
REQ-030 SHALL treat rst mid-operation as overriding all other activity that cycle; queued events are discarded.
REQ-031 SHALL treat keys held through reset as new presses: re-debounced after rst deasserts, producing a fresh press event.

Verification
REQ-032 SHALL cover: keystroke[1] 0->1 held, evt_ready=1 -> key_level[1] rises 6 cycles later, one key_press[1] pulse, event idx=1 repeat=0.
REQ-033 SHALL cover: keystroke[8] glitch 3 cycles -> no key_level change, no event; 5-cycle pulse -> exactly one press event idx=8.
REQ-034 SHALL cover: keystroke[7] and [1] rise same cycle -> events idx=1 then idx=7 on consecutive cycles.
REQ-035 SHALL cover: repeat_en[8]=1, bit 8 held 45 cycles past key_press -> events press, repeat (+32), repeat (+40), none after release.
REQ-036 SHALL cover: evt_ready=0, presses on channels 0-4 then re-press channel 4 -> FIFO holds 0-3, evt_overflow=1; evt_ready=1 drains 0,1,2,3,4 in order.
REQ-037 SHALL cover: rst pulsed with 2 queued events and key 3 held -> evt_valid=0 next cycle; press event idx=3 reissued 6 cycles after rst deasserts.

Source files
------------

// File: rtl/keystroke_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : keystroke_conditioner
// Brief    : Per-key synchroniser, debouncer and auto-repeat with an ordered
//            press/repeat event FIFO.
// Revision : 1.0
// ============================================================================
module keystroke_conditioner #(
    parameter int WIDTH         = 12,
    parameter int DB_CYCLES     = 4,
    parameter int REPEAT_DELAY  = 32,
    parameter int REPEAT_PERIOD = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int IDX_W         = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_raw,
    input  logic             rst,
    input  logic [WIDTH-1:0] keystroke,
    input  logic [WIDTH-1:0] repeat_en,
    output logic [WIDTH-1:0] key_level,
    output logic [WIDTH-1:0] key_press,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_idx,
    output logic             evt_repeat,
    output logic             evt_overflow
);

    localparam int c_DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int c_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX + 1);
    localparam int c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENT_W    = IDX_W + 1;

    localparam logic [c_DB_W-1:0]   c_DB_LAST  = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_DLY = c_HOLD_W'(REPEAT_DELAY);
    localparam logic [c_HOLD_W-1:0] c_HOLD_PER = c_HOLD_W'(REPEAT_PERIOD);
    localparam logic [c_CNT_W-1:0]  c_FULL     = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

    logic [WIDTH-1:0]    r_sync1;
    logic [WIDTH-1:0]    r_sync2;
    logic [WIDTH-1:0]    r_level;
    logic [WIDTH-1:0]    r_press;
    logic [c_DB_W-1:0]   r_db_cnt [WIDTH];
    logic [c_HOLD_W-1:0] r_hold   [WIDTH];
    logic [WIDTH-1:0]    r_phase;
    logic [WIDTH-1:0]    r_pend;
    logic [WIDTH-1:0]    r_prep;
    logic                r_ovf;

    logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr;
    logic [c_PTR_W-1:0]  r_rd;
    logic [c_CNT_W-1:0]  r_count;

    logic [WIDTH-1:0]    w_rpt;
    logic [WIDTH-1:0]    w_pushed;
    logic [IDX_W-1:0]    w_sel;
    logic [c_ENT_W-1:0]  w_entry;
    logic                w_push;
    logic                w_pop;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_rpt    = '0;
        w_pushed = '0;
        w_sel    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // First repeat waits REPEAT_DELAY from the press, later ones REPEAT_PERIOD
            w_rpt[i] = r_level[i] && repeat_en[i] &&
                       (r_phase[i] ? (r_hold[i] == c_HOLD_PER) : (r_hold[i] == c_HOLD_DLY));
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel = IDX_W'(i);
            end
        end
        w_push  = (|r_pend) && (r_count != c_FULL);
        w_pop   = (r_count != '0) && evt_ready;
        w_entry = {w_sel, r_prep[w_sel]};
        for (int i = 0; i < WIDTH; i++) begin
            w_pushed[i] = w_push && (w_sel == IDX_W'(i));
        end
    end

    always_ff @(posedge clk_raw) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_press <= '0;
            r_phase <= '0;
            r_pend  <= '0;
            r_prep  <= '0;
            r_ovf   <= 1'b0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_db_cnt[i] <= '0;
                r_hold[i]   <= '0;
            end
        end else begin
            r_sync1 <= keystroke;
            r_sync2 <= r_sync1;
            r_press <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_DB_LAST) begin
                    r_db_cnt[i] <= '0;
                    r_level[i]  <= ~r_level[i];
                    r_press[i]  <= ~r_level[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end

                if (!r_level[i] || !repeat_en[i]) begin
                    r_hold[i]  <= '0;
                    r_phase[i] <= 1'b0;
                end else if (w_rpt[i]) begin
                    r_hold[i]  <= c_HOLD_W'(1);
                    r_phase[i] <= 1'b1;
                end else begin
                    r_hold[i] <= r_hold[i] + 1'b1;
                end

                // A request landing on a still-queued channel is merged and flagged
                if ((r_press[i] || w_rpt[i]) && r_pend[i] && !w_pushed[i]) begin
                    r_ovf <= 1'b1;
                end
                if (r_press[i]) begin
                    r_pend[i] <= 1'b1;
                    r_prep[i] <= 1'b0;
                end else if (w_rpt[i]) begin
                    r_pend[i] <= 1'b1;
                    r_prep[i] <= (r_pend[i] && !w_pushed[i]) ? r_prep[i] : 1'b1;
                end else if (w_pushed[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end

            if (w_push) begin
                r_wr <= f_next(r_wr);
            end
            if (w_pop) begin
                r_rd <= f_next(r_rd);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the queue is empty
    always_ff @(posedge clk_raw) begin
        if (w_push) begin
            r_mem[r_wr] <= w_entry;
        end
    end

    assign key_level    = r_level;
    assign key_press    = r_press;
    assign evt_valid    = (r_count != '0);
    assign evt_overflow = r_ovf;
    assign {evt_idx, evt_repeat} = evt_valid ? r_mem[r_rd] : '0;

endmodule
`default_nettype wire

// File: tb/tb_keystroke_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keystroke_conditioner
// Brief    : Self-checking bench for keystroke_conditioner (vector table,
//            event scoreboard, hand-written multi-cycle sequences).
// Revision : 1.0
// ============================================================================
module tb_keystroke_conditioner;

    localparam int WIDTH = 12;
    localparam int IDX_W = 4;

    logic             clk_raw = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] keystroke;
    logic [WIDTH-1:0] repeat_en;
    logic [WIDTH-1:0] key_level;
    logic [WIDTH-1:0] key_press;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_repeat;
    logic             evt_overflow;

    keystroke_conditioner dut (
        .clk_raw      (clk_raw),
        .rst          (rst),
        .keystroke    (keystroke),
        .repeat_en    (repeat_en),
        .key_level    (key_level),
        .key_press    (key_press),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_idx      (evt_idx),
        .evt_repeat   (evt_repeat),
        .evt_overflow (evt_overflow)
    );

    always #5 clk_raw = ~clk_raw;

    typedef struct {
        logic [WIDTH-1:0] mask;
        int               len;
        bit               expect_press;
    } vec_t;

    int             checks   = 0;
    int             failures = 0;
    int             cyc      = 0;
    int             press_cnt [WIDTH];
    logic [IDX_W:0] exp_q [$];
    int             pop_cyc [$];

    always @(posedge clk_raw) cyc++;

    // Scoreboard: every accepted event is compared with the oldest expectation
    always @(negedge clk_raw) begin
        logic [IDX_W:0] exp_e;
        for (int i = 0; i < WIDTH; i++) begin
            if (key_press[i] === 1'b1) press_cnt[i]++;
        end
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL evt_unexpected actual idx=%0d rep=%0b required none", evt_idx, evt_repeat);
            end else begin
                exp_e = exp_q.pop_front();
                if ({evt_idx, evt_repeat} !== exp_e) begin
                    failures++;
                    $display("FAIL evt_content actual idx=%0d rep=%0b required idx=%0d rep=%0b",
                             evt_idx, evt_repeat, exp_e[IDX_W:1], exp_e[0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_raw);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < WIDTH; i++) press_cnt[i] = 0;
    endtask

    task automatic expect_evt(input int idx, input bit rep);
        logic [IDX_W:0] e;
        e = {IDX_W'(idx), rep};
        exp_q.push_back(e);
    endtask

    vec_t vecs [6];

    initial begin
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] req;
        int               waited;
        int               p0;

        vecs[0] = '{12'h002, 20, 1'b1};
        vecs[1] = '{12'h100,  3, 1'b0};
        vecs[2] = '{12'h100,  5, 1'b1};
        vecs[3] = '{12'h082, 20, 1'b1};
        vecs[4] = '{12'h801,  4, 1'b1};
        vecs[5] = '{12'h010,  1, 1'b0};

        rst       = 1'b1;
        keystroke = '0;
        repeat_en = '0;
        evt_ready = 1'b1;
        clear_counts();
        tick(3);
        chk("reset_level", int'(key_level), 0);
        chk("reset_press", int'(key_press), 0);
        chk("reset_valid", int'(evt_valid), 0);
        chk("reset_idx", int'(evt_idx), 0);
        chk("reset_repeat", int'(evt_repeat), 0);
        chk("reset_overflow", int'(evt_overflow), 0);
        rst = 1'b0;
        tick(2);

        // Latency from a clean edge to the debounced level and press pulse
        expect_evt(1, 1'b0);
        keystroke[1] = 1'b1;
        tick(5);
        chk("lat_level_early", int'(key_level[1]), 0);
        tick(1);
        chk("lat_level_6", int'(key_level[1]), 1);
        chk("lat_press_6", int'(key_press[1]), 1);
        tick(1);
        chk("lat_press_pulse", int'(key_press[1]), 0);
        keystroke = '0;
        tick(30);
        chk("lat_drained", exp_q.size(), 0);

        for (int v = 0; v < 6; v++) begin
            clear_counts();
            if (vecs[v].expect_press) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (vecs[v].mask[i]) expect_evt(i, 1'b0);
                end
            end
            keystroke = vecs[v].mask;
            tick(vecs[v].len);
            keystroke = '0;
            tick(40);
            for (int i = 0; i < WIDTH; i++) got[i] = (press_cnt[i] == 1);
            req = vecs[v].expect_press ? vecs[v].mask : '0;
            chk($sformatf("vec%0d_press_mask", v), int'(got), int'(req));
            chk($sformatf("vec%0d_drained", v), exp_q.size(), 0);
            chk($sformatf("vec%0d_level_low", v), int'(key_level), 0);
        end

        // Same-cycle presses come out lowest index first, back to back
        expect_evt(1, 1'b0);
        expect_evt(7, 1'b0);
        keystroke = 12'h082;
        waited = 0;
        while (evt_valid !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("order_first_idx", int'(evt_idx), 1);
        tick(1);
        chk("order_second_valid", int'(evt_valid), 1);
        chk("order_second_idx", int'(evt_idx), 7);
        keystroke = '0;
        tick(30);

        // Auto-repeat: press, +32, +40, then nothing once released
        pop_cyc.delete();
        expect_evt(8, 1'b0);
        expect_evt(8, 1'b1);
        expect_evt(8, 1'b1);
        repeat_en[8] = 1'b1;
        keystroke[8] = 1'b1;
        waited = 0;
        while (key_press[8] !== 1'b1 && waited < 20) begin
            tick(1);
            waited++;
        end
        chk("rpt_press_seen", int'(key_press[8]), 1);
        tick(38);
        keystroke = '0;
        tick(40);
        chk("rpt_event_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            p0 = pop_cyc[0];
            chk("rpt_first_gap", pop_cyc[1] - p0, 32);
            chk("rpt_second_gap", pop_cyc[2] - pop_cyc[1], 8);
        end
        chk("rpt_drained", exp_q.size(), 0);
        repeat_en = '0;

        // Overflow: FIFO fills with 0-3, channel 4 pending then re-pressed
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) expect_evt(i, 1'b0);
        keystroke = 12'h01F;
        tick(20);
        chk("ovf_valid", int'(evt_valid), 1);
        chk("ovf_head0", int'(evt_idx), 0);
        chk("ovf_not_yet", int'(evt_overflow), 0);
        keystroke = 12'h00F;
        tick(12);
        keystroke = 12'h01F;
        tick(12);
        chk("ovf_flag", int'(evt_overflow), 1);
        chk("ovf_head_stable", int'(evt_idx), 0);
        evt_ready = 1'b1;
        tick(20);
        chk("ovf_drained", exp_q.size(), 0);
        chk("ovf_sticky", int'(evt_overflow), 1);
        keystroke = '0;
        tick(20);

        // Reset with queued events and key 3 held
        evt_ready = 1'b0;
        keystroke = 12'h00A;
        tick(15);
        chk("rst_pre_valid", int'(evt_valid), 1);
        keystroke = 12'h008;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        chk("rst_valid_cleared", int'(evt_valid), 0);
        chk("rst_ovf_cleared", int'(evt_overflow), 0);
        chk("rst_level_cleared", int'(key_level), 0);
        expect_evt(3, 1'b0);
        tick(5);
        chk("rst_press_early", int'(key_press[3]), 0);
        tick(1);
        chk("rst_press_6", int'(key_press[3]), 1);
        evt_ready = 1'b1;
        tick(10);
        chk("rst_reissued", exp_q.size(), 0);
        keystroke = '0;
        tick(20);
        chk("final_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
